// File: rtl/mmio_uart_tx_pkg.sv
// ---------------------------------------------------------------------------
// mmio_uart_tx_pkg
//   Shared definitions for the memory-mapped UART transmitter:
//   register offsets inside the three-word window, STATUS bit positions,
//   the transmitter state type and a small helper for the STATUS count field.
// ---------------------------------------------------------------------------
package mmio_uart_tx_pkg;

    // Word offsets from BASE_ADR
    localparam logic [1:0] TXDATA_OFS  = 2'd0;
    localparam logic [1:0] STATUS_OFS  = 2'd1;
    localparam logic [1:0] BAUDDIV_OFS = 2'd2;

    // STATUS layout: {9'b0, overflow, count[2:0], busy, empty, full}
    localparam int ST_FULL_BIT     = 0;
    localparam int ST_EMPTY_BIT    = 1;
    localparam int ST_BUSY_BIT     = 2;
    localparam int ST_COUNT_LSB    = 3;
    localparam int ST_COUNT_MSB    = 5;
    localparam int ST_OVERFLOW_BIT = 6;

    // Serial frame states
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uartState_e;

    // The STATUS count field is only three bits wide, so deeper FIFOs
    // show their occupancy clamped at 7.
    function automatic logic [2:0] satCount3(input logic [31:0] c);
        return (c > 32'd7) ? 3'd7 : c[2:0];
    endfunction

endpackage

// File: rtl/mmio_uart_tx_fifo.sv
// ---------------------------------------------------------------------------
// tx_fifo
//   Byte FIFO feeding the UART shifter. Show-ahead: dout always presents
//   the head entry, and pop simply advances past it.
//   Ports:
//     clk, rst    - clock, asynchronous active-high reset
//     push, din   - write request and byte
//     pop         - consume the head byte (ignored when empty)
//     dout        - head byte
//     full, empty - occupancy flags
//     count       - number of stored bytes (0..DEPTH)
//   DEPTH must be a power of two and at least 2.
// ---------------------------------------------------------------------------
module tx_fifo #(
    parameter int DEPTH = 4,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = AW + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic [7:0]    din,
    input  logic          pop,
    output logic [7:0]    dout,
    output logic          full,
    output logic          empty,
    output logic [CW-1:0] count
);

    logic [7:0]    mem_q [DEPTH];
    logic [CW-1:0] wrPtr_q, wrPtr_d;
    logic [CW-1:0] rdPtr_q, rdPtr_d;
    logic          doPush;
    logic          doPop;

    // Pointers carry one extra bit so full and empty are distinguishable;
    // the low AW bits wrap naturally modulo DEPTH. A push into a full FIFO
    // is still accepted when a pop frees the head slot on the same edge.
    always_comb begin
        count   = wrPtr_q - rdPtr_q;
        empty   = (count == '0);
        full    = (count == CW'(DEPTH));
        doPop   = pop && !empty;
        doPush  = push && (!full || doPop);
        wrPtr_d = doPush ? wrPtr_q + 1'b1 : wrPtr_q;
        rdPtr_d = doPop  ? rdPtr_q + 1'b1 : rdPtr_q;
        dout    = mem_q[rdPtr_q[AW-1:0]];
    end

    // Pointer registers; reset empties the FIFO by aligning both pointers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
        end else begin
            wrPtr_q <= wrPtr_d;
            rdPtr_q <= rdPtr_d;
        end
    end

    // Storage needs no reset: stale entries are never visible while empty.
    always_ff @(posedge clk) begin
        if (doPush) begin
            mem_q[wrPtr_q[AW-1:0]] <= din;
        end
    end

endmodule

// File: rtl/mmio_uart_tx.sv
// ---------------------------------------------------------------------------
// mmio_uart_tx
//   Memory-mapped UART transmitter occupying three word addresses:
//     BASE_ADR+0 TXDATA  (write: queue a byte, read: 0)
//     BASE_ADR+1 STATUS  (read; clears the sticky overflow flag)
//     BASE_ADR+2 BAUDDIV (read/write; bit time = BAUDDIV+1 clocks)
//   Ports:
//     clk, rst            - clock, asynchronous active-high reset
//     memread, memwrite   - CPU strobes
//     adr, writedata      - CPU word address and write data
//     memdata             - registered read data (one-cycle latency)
//     sel                 - combinational address match for the read mux
//     tx                  - serial output, idles high
// ---------------------------------------------------------------------------
module mmio_uart_tx
    import mmio_uart_tx_pkg::*;
#(
    parameter logic [15:0] BASE_ADR   = 16'hFF00,
    parameter logic [15:0] DIV_RESET  = 16'd433,
    parameter int          FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        memread,
    input  logic        memwrite,
    input  logic [15:0] adr,
    input  logic [15:0] writedata,
    output logic [15:0] memdata,
    output logic        sel,
    output logic        tx
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic [15:0]  adrOfs;
    logic [1:0]   regOfs;
    logic         wrAccept;
    logic         rdAccept;
    logic         txdataWrite;
    logic         ovfEvent;
    logic [15:0]  statusWord;

    logic [15:0]  memdata_q, memdata_d;
    logic [15:0]  baudDiv_q, baudDiv_d;
    logic         overflow_q, overflow_d;

    uartState_e   state_q, state_d;
    logic [15:0]  bitTimer_q, bitTimer_d;
    logic [15:0]  reload_q, reload_d;
    logic [2:0]   bitCnt_q, bitCnt_d;
    logic [7:0]   shift_q, shift_d;
    logic         startFrame;

    logic         fifoPop;
    logic [7:0]   fifoDout;
    logic         fifoFull;
    logic         fifoEmpty;
    logic [CW-1:0] fifoCount;

    tx_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (txdataWrite),
        .din   (writedata[7:0]),
        .pop   (fifoPop),
        .dout  (fifoDout),
        .full  (fifoFull),
        .empty (fifoEmpty),
        .count (fifoCount)
    );

    // Address decode. The subtraction wraps modulo 2^16, so the window is
    // matched correctly even when BASE_ADR sits near the top of the map.
    // A combined read+write is treated as a write only, leaving memdata alone.
    always_comb begin
        adrOfs      = adr - BASE_ADR;
        sel         = (adrOfs < 16'd3);
        regOfs      = adrOfs[1:0];
        wrAccept    = memwrite && sel;
        rdAccept    = memread && sel && !memwrite;
        txdataWrite = wrAccept && (regOfs == TXDATA_OFS);
        ovfEvent    = txdataWrite && fifoFull && !fifoPop;
    end

    // STATUS word assembled from live state.
    always_comb begin
        statusWord                               = '0;
        statusWord[ST_OVERFLOW_BIT]              = overflow_q;
        statusWord[ST_COUNT_MSB:ST_COUNT_LSB]    = satCount3(32'(fifoCount));
        statusWord[ST_BUSY_BIT]                  = (state_q != IDLE);
        statusWord[ST_EMPTY_BIT]                 = fifoEmpty;
        statusWord[ST_FULL_BIT]                  = fifoFull;
    end

    // Register-file next state: read capture, BAUDDIV write and the sticky
    // overflow flag. An overflow on the same edge as a STATUS read keeps the
    // flag set so the event is never lost.
    always_comb begin
        memdata_d  = memdata_q;
        baudDiv_d  = baudDiv_q;
        overflow_d = overflow_q;
        if (rdAccept) begin
            case (regOfs)
                STATUS_OFS:  memdata_d = statusWord;
                BAUDDIV_OFS: memdata_d = baudDiv_q;
                default:     memdata_d = 16'h0000;
            endcase
        end
        if (wrAccept && (regOfs == BAUDDIV_OFS)) begin
            baudDiv_d = writedata;
        end
        if (ovfEvent) begin
            overflow_d = 1'b1;
        end else if (rdAccept && (regOfs == STATUS_OFS)) begin
            overflow_d = 1'b0;
        end
    end

    // Register-file state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            memdata_q  <= '0;
            baudDiv_q  <= DIV_RESET;
            overflow_q <= 1'b0;
        end else begin
            memdata_q  <= memdata_d;
            baudDiv_q  <= baudDiv_d;
            overflow_q <= overflow_d;
        end
    end

    assign memdata = memdata_q;

    // Transmit FSM next state and serial output. The bit timer counts down
    // from the divisor latched at frame start, so each bit lasts reload+1
    // clocks and a BAUDDIV write mid-frame only affects the next frame.
    // A new frame can start from IDLE or straight out of the last STOP
    // cycle, which keeps queued frames back-to-back.
    always_comb begin
        state_d    = state_q;
        bitTimer_d = bitTimer_q;
        reload_d   = reload_q;
        bitCnt_d   = bitCnt_q;
        shift_d    = shift_q;
        fifoPop    = 1'b0;
        startFrame = 1'b0;
        tx         = 1'b1;
        case (state_q)
            IDLE: begin
                startFrame = !fifoEmpty;
            end
            START: begin
                tx = 1'b0;
                if (bitTimer_q == '0) begin
                    bitTimer_d = reload_q;
                    bitCnt_d   = '0;
                    state_d    = DATA;
                end else begin
                    bitTimer_d = bitTimer_q - 16'd1;
                end
            end
            DATA: begin
                tx = shift_q[0];
                if (bitTimer_q == '0) begin
                    bitTimer_d = reload_q;
                    if (bitCnt_q == 3'd7) begin
                        state_d = STOP;
                    end else begin
                        shift_d  = {1'b0, shift_q[7:1]};
                        bitCnt_d = bitCnt_q + 3'd1;
                    end
                end else begin
                    bitTimer_d = bitTimer_q - 16'd1;
                end
            end
            STOP: begin
                if (bitTimer_q == '0) begin
                    if (!fifoEmpty) begin
                        startFrame = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    bitTimer_d = bitTimer_q - 16'd1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        if (startFrame) begin
            fifoPop    = 1'b1;
            shift_d    = fifoDout;
            reload_d   = baudDiv_q;
            bitTimer_d = baudDiv_q;
            bitCnt_d   = '0;
            state_d    = START;
        end
    end

    // Transmit FSM state. Reset returns to IDLE at once, which forces tx high
    // without waiting for a clock edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            bitTimer_q <= '0;
            reload_q   <= '0;
            bitCnt_q   <= '0;
            shift_q    <= '0;
        end else begin
            state_q    <= state_d;
            bitTimer_q <= bitTimer_d;
            reload_q   <= reload_d;
            bitCnt_q   <= bitCnt_d;
            shift_q    <= shift_d;
        end
    end

endmodule

// File: tb/tb_mmio_uart_tx.sv
// ---------------------------------------------------------------------------
// tb_mmio_uart_tx
//   Directed bench for mmio_uart_tx with a frame-level reference model.
//   The model keeps the queued bytes and the list of line samples still to
//   be sent, and is compared against the DUT after every rising edge.
// ---------------------------------------------------------------------------
module tb_mmio_uart_tx;

    localparam logic [15:0] BASE  = 16'hFF00;
    localparam logic [15:0] DIVR  = 16'd433;
    localparam int          DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        memread = 1'b0;
    logic        memwrite = 1'b0;
    logic [15:0] adr = BASE;
    logic [15:0] writedata = 16'h0000;
    logic [15:0] memdata;
    logic        sel;
    logic        tx;

    int checks = 0;
    int errors = 0;

    mmio_uart_tx #(
        .BASE_ADR   (BASE),
        .DIV_RESET  (DIVR),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .memread   (memread),
        .memwrite  (memwrite),
        .adr       (adr),
        .writedata (writedata),
        .memdata   (memdata),
        .sel       (sel),
        .tx        (tx)
    );

    always #5 clk = ~clk;

    // Single comparison point: counts every check and reports failures.
    task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Drives one bus cycle starting at a falling edge; returns on the next
    // falling edge with strobes dropped, so back-to-back calls hit
    // consecutive rising edges.
    task automatic applyStimulus(input logic rd, input logic wr, input logic [15:0] a, input logic [15:0] d);
        memread   = rd;
        memwrite  = wr;
        adr       = a;
        writedata = d;
        @(negedge clk);
        memread   = 1'b0;
        memwrite  = 1'b0;
    endtask

    // ---------------- reference model ----------------
    byte unsigned mQ[$];
    bit           mWave[$];
    bit           mTx   = 1'b1;
    bit           mBusy = 1'b0;
    bit           mOvf  = 1'b0;
    int unsigned  mBaud = DIVR;
    logic [15:0]  mMem  = 16'h0000;

    // Append one whole frame of line samples: start, 8 data bits LSB
    // first, stop; each bit held for div+1 clocks.
    task automatic buildFrame(input byte unsigned b, input int unsigned div);
        bit bits[10];
        bits[0] = 1'b0;
        for (int i = 0; i < 8; i++) bits[i+1] = b[i];
        bits[9] = 1'b1;
        for (int i = 0; i < 10; i++)
            for (int k = 0; k <= int'(div); k++) mWave.push_back(bits[i]);
    endtask

    // Model update, evaluated with the values present just before each edge.
    always @(posedge clk or posedge rst) begin
        int          ofs;
        bit          inWin, rdOk, wrOk, ovfEv;
        int unsigned cnt;
        logic [15:0] status;
        if (rst) begin
            mQ.delete();
            mWave.delete();
            mTx   = 1'b1;
            mBusy = 1'b0;
            mOvf  = 1'b0;
            mBaud = DIVR;
            mMem  = 16'h0000;
        end else begin
            ofs   = int'(adr) - int'(BASE);
            inWin = (ofs >= 0) && (ofs <= 2);
            rdOk  = memread && inWin && !memwrite;
            wrOk  = memwrite && inWin;
            cnt   = (mQ.size() > 7) ? 7 : mQ.size();
            status = 16'(mOvf) * 16'h0040 + 16'(cnt) * 16'h0008 + 16'(mBusy) * 16'h0004
                   + ((mQ.size() == 0) ? 16'h0002 : 16'h0000)
                   + ((mQ.size() == DEPTH) ? 16'h0001 : 16'h0000);
            if (rdOk) mMem = (ofs == 1) ? status : (ofs == 2) ? 16'(mBaud) : 16'h0000;
            ovfEv = 1'b0;
            if (mWave.size() == 0 && mQ.size() > 0) buildFrame(mQ.pop_front(), mBaud);
            if (wrOk && ofs == 0) begin
                if (mQ.size() < DEPTH) mQ.push_back(writedata[7:0]);
                else ovfEv = 1'b1;
            end
            if (wrOk && ofs == 2) mBaud = writedata;
            if (ovfEv) mOvf = 1'b1;
            else if (rdOk && ofs == 1) mOvf = 1'b0;
            if (mWave.size() > 0) begin
                mTx   = mWave.pop_front();
                mBusy = 1'b1;
            end else begin
                mTx   = 1'b1;
                mBusy = 1'b0;
            end
        end
    end

    // Compare DUT against the model shortly after every rising edge.
    initial begin
        int  o;
        forever begin
            @(posedge clk);
            #1;
            o = int'(adr) - int'(BASE);
            checkOutput("cyc tx", 16'(tx), 16'(mTx));
            checkOutput("cyc memdata", memdata, mMem);
            checkOutput("cyc sel", 16'(sel), 16'((o >= 0) && (o <= 2)));
        end
    end

    // ---------------- directed sequence ----------------
    initial begin
        bit          seq29[10];
        logic [20:0] seq31;
        logic [9:0]  s29;
        bit          allHigh;

        s29   = 10'b1101001010;
        seq31 = 21'b1_1001000100_1000100010;
        for (int i = 0; i < 10; i++) seq29[i] = s29[i];

        repeat (3) @(negedge clk);
        rst = 1'b0;

        // Reset state
        checkOutput("reset tx", 16'(tx), 16'h0001);
        checkOutput("reset memdata", memdata, 16'h0000);
        applyStimulus(1, 0, BASE + 16'd1, 16'h0000);
        checkOutput("reset status", memdata, 16'h0002);
        applyStimulus(1, 0, BASE + 16'd2, 16'h0000);
        checkOutput("reset bauddiv", memdata, 16'h01B1);
        applyStimulus(1, 0, BASE, 16'h0000);
        checkOutput("txdata reads zero", memdata, 16'h0000);
        applyStimulus(1, 0, BASE - 16'd1, 16'h0000);
        checkOutput("sel below window", 16'(sel), 16'h0000);
        checkOutput("no read outside window", memdata, 16'h0000);

        // Writes to STATUS and past the window do nothing
        applyStimulus(0, 1, BASE + 16'd1, 16'hFFFF);
        applyStimulus(0, 1, BASE + 16'd3, 16'h00AA);
        applyStimulus(1, 0, BASE + 16'd1, 16'h0000);
        checkOutput("ignored writes status", memdata, 16'h0002);

        // Single frame 0xA5 at BAUDDIV=3; upper write bits ignored
        applyStimulus(0, 1, BASE + 16'd2, 16'h0003);
        applyStimulus(0, 1, BASE, 16'hFFA5);
        applyStimulus(1, 0, BASE + 16'd1, 16'h0000);
        checkOutput("queued status", memdata, 16'h0008);
        for (int i = 0; i < 40; i++) begin
            checkOutput("frame A5 bit", 16'(tx), 16'(seq29[i/4]));
            applyStimulus(1, 0, BASE + 16'd1, 16'h0000);
            checkOutput("busy during frame", 16'(memdata[2]), 16'h0001);
        end
        checkOutput("idle after A5", 16'(tx), 16'h0001);
        applyStimulus(1, 0, BASE + 16'd1, 16'h0000);
        checkOutput("status after A5", memdata, 16'h0002);

        // Fill the FIFO and overflow it
        for (int i = 1; i <= 6; i++) applyStimulus(0, 1, BASE, 16'(i));
        applyStimulus(1, 0, BASE + 16'd1, 16'h0000);
        checkOutput("overflow status", memdata, 16'h0065);
        applyStimulus(1, 0, BASE + 16'd1, 16'h0000);
        checkOutput("overflow cleared", memdata, 16'h0025);
        repeat (210) @(negedge clk);

        // Two queued frames back-to-back at BAUDDIV=1
        applyStimulus(0, 1, BASE + 16'd2, 16'h0001);
        applyStimulus(0, 1, BASE, 16'h0011);
        applyStimulus(0, 1, BASE, 16'h0022);
        for (int i = 0; i < 42; i++) begin
            checkOutput("contiguous frames bit", 16'(tx), 16'(seq31[i/2]));
            @(negedge clk);
        end

        // BAUDDIV change during a frame applies to the next one
        applyStimulus(0, 1, BASE, 16'h0033);
        applyStimulus(0, 1, BASE + 16'd2, 16'h0000);
        applyStimulus(0, 1, BASE, 16'h0044);
        repeat (40) @(negedge clk);

        // Reset during DATA bit 3 with a second byte queued
        applyStimulus(0, 1, BASE + 16'd2, 16'h0003);
        applyStimulus(0, 1, BASE, 16'h00A5);
        applyStimulus(0, 1, BASE, 16'h005A);
        repeat (17) @(negedge clk);
        checkOutput("bit 3 of A5 before reset", 16'(tx), 16'h0000);
        rst = 1'b1;
        #1;
        checkOutput("tx high at reset", 16'(tx), 16'h0001);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        applyStimulus(1, 0, BASE + 16'd1, 16'h0000);
        checkOutput("fifo empty after reset", memdata, 16'h0002);
        applyStimulus(1, 0, BASE + 16'd2, 16'h0000);
        checkOutput("bauddiv after reset", memdata, 16'h01B1);
        allHigh = 1'b1;
        repeat (60) begin
            @(negedge clk);
            if (tx !== 1'b1) allHigh = 1'b0;
        end
        checkOutput("no frame after reset", 16'(allHigh), 16'h0001);

        // Simultaneous read and write on BAUDDIV
        applyStimulus(1, 1, BASE + 16'd2, 16'h0007);
        checkOutput("rd+wr keeps memdata", memdata, 16'h01B1);
        applyStimulus(1, 0, BASE + 16'd2, 16'h0000);
        checkOutput("bauddiv written", memdata, 16'h0007);

        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mmio_uart_tx.md
MMIO_UART_TX -- requirements
Module: mmio_uart_tx

Interface
REQ-001 SHALL have parameter BASE_ADR, default 16'hFF00, meaning the first of three consecutive word addresses this responder decodes.
REQ-002 SHALL have parameter DIV_RESET, default 16'd433, meaning the BAUDDIV value loaded at reset.
REQ-003 SHALL have parameter FIFO_DEPTH, default 4, meaning the number of byte entries in the transmit FIFO; the value SHALL be a power of two.
REQ-004 SHALL have ports, in this order:
- clk  input  1  single clock; all state on rising edge.
- rst  input  1  asynchronous, active-high reset.
- memread  input  1  CPU read strobe.
- memwrite  input  1  CPU write strobe.
- adr  input  16  CPU word address.
- writedata  input  16  CPU write data.
- memdata  output  16  registered read data.
- sel  output  1  combinational; high when adr is in BASE_ADR..BASE_ADR+2, used by top-level read mux.
- tx  output  1  serial line; idles high.

Function
REQ-005 SHALL decode offset 0 as TXDATA (write-only), offset 1 as STATUS (read-only), offset 2 as BAUDDIV (read/write).
REQ-006 SHALL act on a write only when memwrite and sel are both high at a clk edge.
REQ-007 SHALL act on a read only when memread and sel are both high at a clk edge.
REQ-008 A TXDATA write SHALL push writedata[7:0] into the FIFO, and SHALL ignore writedata[15:8].
REQ-009 A TXDATA write while the FIFO is full SHALL be dropped, and SHALL set a sticky overflow flag.
REQ-010 STATUS SHALL read {9'b0, overflow, count[2:0], busy, empty, full}:
- count is the FIFO occupancy, saturating display at 7.
- busy is high when the FSM is not IDLE.
REQ-011 A STATUS read SHALL clear overflow on the same edge it is captured. A simultaneous overflow event SHALL win, leaving overflow set.
REQ-012 A read SHALL register the selected register into memdata at the strobe edge, giving one-cycle latency. memdata SHALL hold until the next accepted read. Reading TXDATA SHALL return 16'h0000.
REQ-013 If memread and memwrite are high on the same edge, the write SHALL be performed, and memdata SHALL be unchanged.
REQ-014 Writes to offsets outside 0..2 and writes to STATUS SHALL have no effect.
REQ-015 FSM states SHALL be IDLE, START, DATA, STOP.
REQ-016 FSM transitions SHALL be:
- IDLE->START when the FIFO is non-empty. This edge pops the head byte into the shift register and latches BAUDDIV into the bit timer reload.
- START->DATA after one bit time.
- DATA->DATA for 8 bits, LSB first.
- DATA->STOP after bit 7.
- STOP->START directly if the FIFO is non-empty, with the same pop/latch as IDLE->START.
- STOP->IDLE otherwise.
REQ-017 One bit time SHALL equal latched BAUDDIV+1 clk cycles. BAUDDIV=0 SHALL give 1 cycle per bit.
REQ-018 tx SHALL be 1 in IDLE and STOP, 0 in START, and the current shift bit in DATA.
REQ-019 A BAUDDIV write during a frame SHALL affect only the next frame.
REQ-020 A simultaneous push and pop on a full FIFO SHALL succeed without overflow. A simultaneous push and pop on an empty FIFO SHALL be impossible, because a pop requires non-empty.
REQ-021 FIFO pointers SHALL wrap modulo FIFO_DEPTH. Occupancy SHALL be tracked with an extra pointer bit or a counter.

Reset
REQ-022 On rst high, asynchronously:
- memdata=0, tx=1, overflow=0.
- FIFO empty with pointers at 0.
- FSM in IDLE with bit timer and bit counter at 0.
- BAUDDIV set to DIV_RESET.
REQ-023 Reset asserted mid-frame SHALL abort the frame immediately, with tx high in the same cycle, and SHALL discard queued bytes.
REQ-024 sel SHALL remain purely combinational from adr regardless of rst.

Structure
REQ-025 A shared package SHALL hold:
- the register offset constants TXDATA_OFS=0, STATUS_OFS=1, BAUDDIV_OFS=2;
- the STATUS bit index constants;
- the FSM state typedef.
REQ-026 The FIFO SHALL be a sub-module named tx_fifo with ports clk, rst, push, din[7:0], pop, dout[7:0], full, empty, count.
REQ-027 Decode, registers and FSM SHALL live in mmio_uart_tx.

Verification
REQ-028 Reset, then read STATUS -> memdata=16'h0002 one cycle later, and tx=1.
REQ-029 Write BAUDDIV=3, then TXDATA=8'hA5 -> tx waveform SHALL be, for 4 cycles each bit:
- start 0;
- data bits 1,0,1,0,0,1,0,1;
- stop 1.
The total frame SHALL be 40 cycles, and busy SHALL be high throughout.
REQ-030 Five back-to-back TXDATA writes 8'h01..8'h05 while idle:
- The first write pops immediately, so all five are accepted with no overflow.
- A sixth write before any further pop SHALL set overflow.
- STATUS SHALL read overflow=1, full=1.
- A following STATUS read SHALL show overflow=0.
REQ-031 Queue 8'h11 and 8'h22 -> the frames SHALL be contiguous, with a single stop bit followed directly by the next start bit and no idle gap.
REQ-032 Assert rst during DATA bit 3 -> tx=1 while rst is high, FIFO empty, BAUDDIV=DIV_RESET; after release no frame SHALL be transmitted.
REQ-033 Assert memread and memwrite together on BAUDDIV with writedata=16'h0007 -> memdata unchanged; a subsequent read SHALL return 16'h0007.
